recovery_arbiter: RTL and testbench
===================================

RECOVERY_ARBITER -- requirements
Module: recovery_arbiter

Interface
REQ-001 SHALL have parameters: NUM_SRC, default 3, number of recovery request sources; source 0 is the commit stage, sources 1..N-1 are RW-stage lanes.
REQ-002 SHALL have parameters: ADDR_WIDTH, default 32, PC width; AL_DEPTH, default 64, ActiveList entries (any value >=2); INSN_BYTES, default 4; WDOG_CYCLES, default 1024.
REQ-003 SHALL derive AL_IDX_W = clog2(AL_DEPTH) and SRC_W = max(1, clog2(NUM_SRC)).
REQ-004 SHALL have ports, in order (name, direction, width, meaning):
 clk  in  1  clock, single domain
 rst  in  1  reset, synchronous, active-high
 req_valid  in  NUM_SRC  recovery request per source
 req_al_ptr  in  NUM_SRC*AL_IDX_W  ActiveList index of the excepting op
 req_refetch_type  in  NUM_SRC*3  RefetchType per source
 req_pc  in  NUM_SRC*ADDR_WIDTH  PC of the excepting op
 al_head_ptr  in  AL_IDX_W  ActiveList head, used as the age origin
 al_flush_tail_ptr  in  AL_IDX_W  ActiveList tail at detection
 csr_target  in  ADDR_WIDTH  trap/MRET target from the CSR unit
 rmt_busy, iq_busy  in  1 each  RMT / IQ recovery still in progress
 replay_flushed, wakeup_flushed  in  1 each  flushed ops still resident
 phase  out  2  COMMIT=0, RECOVER_0=1, RECOVER_1=2
 to_recovery_phase  out  1  high throughout RECOVER_0
 to_commit_phase  out  1  recovery completes this cycle
 recovery_from_commit  out  1  winner was source 0
 winner_src  out  SRC_W  winning source index
 recovered_pc  out  ADDR_WIDTH  refetch PC, valid in RECOVER_0, else 0
 flush_head_ptr, flush_tail_ptr  out  AL_IDX_W each  flush range
 sq_tail_inc  out  1  store-queue recovery tail +1
 csr_trigger  out  1  CSR exception request
 unable_to_start  out  1  sources must not request
 watchdog_err  out  1  sticky; RECOVER_1 exceeded WDOG_CYCLES
 recovery_count  out  32  completed recoveries, wraps

Function
REQ-005 SHALL sample requests only when phase==COMMIT; requests in other phases SHALL be ignored.
REQ-006 SHALL compute age_i = (req_al_ptr_i - al_head_ptr) mod AL_DEPTH, using explicit wrap for non-power-of-two AL_DEPTH.
REQ-007 SHALL select source 0 when it is valid; otherwise it SHALL select the valid source with the smallest age, with ties going to the lowest index.
REQ-008 SHALL register the winner's pc, type, ptr, index and al_flush_tail_ptr at the request edge; phase SHALL become RECOVER_0 on the next cycle.
REQ-009 SHALL make RECOVER_0 last exactly 1 cycle and then enter RECOVER_1.
REQ-010 In RECOVER_1, to_commit_phase SHALL equal !(rmt_busy|iq_busy) combinationally, and phase SHALL become COMMIT on the following cycle.
REQ-011 In RECOVER_0, recovered_pc SHALL be: THIS_PC or BRANCH_TARGET -> pc; NEXT_PC or STORE_NEXT_PC -> pc+INSN_BYTES (mod 2^ADDR_WIDTH); CSR types -> csr_target.
REQ-012 csr_trigger SHALL be high only in RECOVER_0, with a CSR type, and with winner_src==0.
REQ-013 A CSR type from source >0 SHALL be treated as THIS_PC.
REQ-014 flush_head_ptr SHALL be ptr for THIS_PC and THIS_PC_TO_CSR, and (ptr+1) mod AL_DEPTH otherwise; flush_tail_ptr SHALL be the latched tail.
REQ-015 sq_tail_inc SHALL be high when the latched type is STORE_NEXT_PC.
REQ-016 unable_to_start SHALL be (phase!=COMMIT)|rmt_busy|iq_busy|replay_flushed|wakeup_flushed.
REQ-017 The watchdog counter SHALL clear on entering RECOVER_1 and increment each RECOVER_1 cycle; on reaching WDOG_CYCLES it SHALL set watchdog_err, with no forced exit.
REQ-018 recovery_count SHALL increment on each to_commit_phase.

Reset
REQ-019 When rst is high at a clk edge, the block SHALL go to phase COMMIT, clear all latched state, the counters and watchdog_err, and drive every output to 0, regardless of the current phase.

Structure
REQ-020 RecoveryPhase and the RefetchType encodings SHALL live in the shared RecoveryTypes package; parameters SHALL stay local to the module.
REQ-021 The block SHALL contain one sub-module, recovery_age_select: a combinational oldest-valid picker parameterised by NUM_SRC and AL_DEPTH.

Verification
REQ-022 Scenario: head=60, AL_DEPTH=64, src1 ptr=2, src2 ptr=62, both valid -> winner_src=2, flush_head=63.
REQ-023 Scenario: src0 THIS_PC_TO_CSR plus older src1 in the same cycle -> winner 0, csr_trigger in RECOVER_0, recovered_pc=csr_target.
REQ-024 Scenario: src1 NEXT_PC with pc=0xFFFFFFFC -> recovered_pc=0x0, phase sequence 1 then 2.
REQ-025 Scenario: rmt_busy held for 5 cycles of RECOVER_1 -> to_commit_phase high in the 6th, COMMIT next, recovery_count=1.
REQ-026 Scenario: WDOG_CYCLES=8, iq_busy stuck -> watchdog_err rises at cycle 8 and stays high; asserting rst -> COMMIT and watchdog_err=0.
REQ-027 Scenario: a request asserted during RECOVER_1 -> it is ignored, and unable_to_start=1.

Source files
------------

// File: rtl/recovery_arbiter_pkg.sv
// Shared recovery types: the arbiter phase encoding and the RefetchType codes
// carried by every recovery request.
package recovery_arbiter_pkg;

    typedef enum logic [1:0] {
        PH_COMMIT    = 2'd0,
        PH_RECOVER_0 = 2'd1,
        PH_RECOVER_1 = 2'd2
    } recovery_phase_e;

    typedef enum logic [2:0] {
        RT_THIS_PC        = 3'd0,
        RT_NEXT_PC        = 3'd1,
        RT_BRANCH_TARGET  = 3'd2,
        RT_STORE_NEXT_PC  = 3'd3,
        RT_THIS_PC_TO_CSR = 3'd4,
        RT_NEXT_PC_TO_CSR = 3'd5
    } refetch_type_e;

    function automatic logic is_csr_type(input logic [2:0] t);
        return (t == RT_THIS_PC_TO_CSR) || (t == RT_NEXT_PC_TO_CSR);
    endfunction

endpackage

// File: rtl/recovery_arbiter_age_select.sv
// Combinational oldest-valid picker: age is the ActiveList distance from the head,
// smallest age wins, ties go to the lowest source index.
module recovery_age_select #(
    parameter int  NUM_SRC  = 3,
    parameter int  AL_DEPTH = 64,
    localparam int AL_IDX_W = $clog2(AL_DEPTH),
    localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0]          req_valid_i,
    input  logic [NUM_SRC*AL_IDX_W-1:0] req_al_ptr_i,
    input  logic [AL_IDX_W-1:0]         head_ptr_i,
    output logic                        any_valid_o,
    output logic [SRC_W-1:0]            oldest_src_o
);

    logic [AL_IDX_W-1:0] age [NUM_SRC];
    logic [AL_IDX_W-1:0] best_age;

    // Explicit wrap keeps the distance correct when AL_DEPTH is not a power of two.
    function automatic logic [AL_IDX_W-1:0] wrap_age(input logic [AL_IDX_W-1:0] p,
                                                      input logic [AL_IDX_W-1:0] h);
        logic [AL_IDX_W:0] diff;
        if (p >= h) diff = {1'b0, p} - {1'b0, h};
        else        diff = {1'b0, p} + (AL_IDX_W+1)'(AL_DEPTH) - {1'b0, h};
        return diff[AL_IDX_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            age[i] = wrap_age(req_al_ptr_i[i*AL_IDX_W +: AL_IDX_W], head_ptr_i);
        end
    end

    always_comb begin
        any_valid_o  = 1'b0;
        oldest_src_o = '0;
        best_age     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_valid_i[i] && (!any_valid_o || (age[i] < best_age))) begin
                any_valid_o  = 1'b1;
                oldest_src_o = SRC_W'(i);
                best_age     = age[i];
            end
        end
    end

endmodule

// File: rtl/recovery_arbiter.sv
// Recovery arbiter: grants one recovery per COMMIT cycle (commit stage first, else the
// oldest ActiveList op) and sequences COMMIT -> RECOVER_0 -> RECOVER_1 -> COMMIT.
module recovery_arbiter
    import recovery_arbiter_pkg::*;
#(
    parameter int  NUM_SRC     = 3,
    parameter int  ADDR_WIDTH  = 32,
    parameter int  AL_DEPTH    = 64,
    parameter int  INSN_BYTES  = 4,
    parameter int  WDOG_CYCLES = 1024,
    localparam int AL_IDX_W    = $clog2(AL_DEPTH),
    localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req_valid,
    input  logic [NUM_SRC*AL_IDX_W-1:0]   req_al_ptr,
    input  logic [NUM_SRC*3-1:0]          req_refetch_type,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] req_pc,
    input  logic [AL_IDX_W-1:0]           al_head_ptr,
    input  logic [AL_IDX_W-1:0]           al_flush_tail_ptr,
    input  logic [ADDR_WIDTH-1:0]         csr_target,
    input  logic                          rmt_busy,
    input  logic                          iq_busy,
    input  logic                          replay_flushed,
    input  logic                          wakeup_flushed,
    output logic [1:0]                    phase,
    output logic                          to_recovery_phase,
    output logic                          to_commit_phase,
    output logic                          recovery_from_commit,
    output logic [SRC_W-1:0]              winner_src,
    output logic [ADDR_WIDTH-1:0]         recovered_pc,
    output logic [AL_IDX_W-1:0]           flush_head_ptr,
    output logic [AL_IDX_W-1:0]           flush_tail_ptr,
    output logic                          sq_tail_inc,
    output logic                          csr_trigger,
    output logic                          unable_to_start,
    output logic                          watchdog_err,
    output logic [31:0]                   recovery_count
);

    localparam int WDOG_W = ($clog2(WDOG_CYCLES + 1) > 0) ? $clog2(WDOG_CYCLES + 1) : 1;

    recovery_phase_e       phase_q, phase_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]            type_q, type_d;
    logic [AL_IDX_W-1:0]   ptr_q, ptr_d;
    logic [AL_IDX_W-1:0]   tail_q, tail_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic                  from_commit_q, from_commit_d;
    logic [WDOG_W-1:0]     wdog_cnt_q, wdog_cnt_d;
    logic                  wdog_err_q, wdog_err_d;
    logic [31:0]           rec_cnt_q, rec_cnt_d;

    logic                  any_valid;
    logic [SRC_W-1:0]      pick_src;
    logic [SRC_W-1:0]      win_src;
    logic [2:0]            win_type;
    logic                  busy;
    logic                  wdog_hit;
    logic [AL_IDX_W-1:0]   ptr_inc;

    // Only the commit stage may raise CSR traps; CSR (and unused) codes elsewhere refetch this PC.
    function automatic logic [2:0] canon_type(input logic [2:0] t, input logic from_src0);
        if (t > RT_NEXT_PC_TO_CSR)             return RT_THIS_PC;
        if (is_csr_type(t) && !from_src0)      return RT_THIS_PC;
        return t;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] refetch_pc(input logic [2:0]            t,
                                                          input logic [ADDR_WIDTH-1:0] pc,
                                                          input logic [ADDR_WIDTH-1:0] csr);
        case (t)
            RT_NEXT_PC, RT_STORE_NEXT_PC:         return pc + ADDR_WIDTH'(INSN_BYTES);
            RT_THIS_PC_TO_CSR, RT_NEXT_PC_TO_CSR: return csr;
            default:                              return pc;
        endcase
    endfunction

    recovery_age_select #(
        .NUM_SRC  (NUM_SRC),
        .AL_DEPTH (AL_DEPTH)
    ) u_age_select (
        .req_valid_i  (req_valid),
        .req_al_ptr_i (req_al_ptr),
        .head_ptr_i   (al_head_ptr),
        .any_valid_o  (any_valid),
        .oldest_src_o (pick_src)
    );

    assign busy     = rmt_busy | iq_busy;
    assign win_src  = req_valid[0] ? '0 : pick_src;
    assign win_type = canon_type(req_refetch_type[int'(win_src)*3 +: 3], (win_src == '0));
    assign wdog_hit = (({1'b0, wdog_cnt_q} + 1'b1) >= (WDOG_W+1)'(WDOG_CYCLES));
    assign ptr_inc  = (ptr_q == AL_IDX_W'(AL_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        phase_d       = phase_q;
        pc_d          = pc_q;
        type_d        = type_q;
        ptr_d         = ptr_q;
        tail_d        = tail_q;
        src_d         = src_q;
        from_commit_d = from_commit_q;
        wdog_cnt_d    = wdog_cnt_q;
        wdog_err_d    = wdog_err_q;
        rec_cnt_d     = rec_cnt_q;
        case (phase_q)
            PH_COMMIT: begin
                if (any_valid) begin
                    phase_d       = PH_RECOVER_0;
                    pc_d          = req_pc[int'(win_src)*ADDR_WIDTH +: ADDR_WIDTH];
                    type_d        = win_type;
                    ptr_d         = req_al_ptr[int'(win_src)*AL_IDX_W +: AL_IDX_W];
                    tail_d        = al_flush_tail_ptr;
                    src_d         = win_src;
                    from_commit_d = (win_src == '0);
                end
            end
            PH_RECOVER_0: begin
                phase_d    = PH_RECOVER_1;
                wdog_cnt_d = '0;
            end
            PH_RECOVER_1: begin
                // The watchdog only flags a hang; recovery still waits for RMT/IQ.
                if (wdog_cnt_q != WDOG_W'(WDOG_CYCLES)) wdog_cnt_d = wdog_cnt_q + 1'b1;
                if (wdog_hit) wdog_err_d = 1'b1;
                if (!busy) begin
                    phase_d   = PH_COMMIT;
                    rec_cnt_d = rec_cnt_q + 1'b1;
                end
            end
            default: phase_d = PH_COMMIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_COMMIT;
            pc_q          <= '0;
            type_q        <= '0;
            ptr_q         <= '0;
            tail_q        <= '0;
            src_q         <= '0;
            from_commit_q <= 1'b0;
            wdog_cnt_q    <= '0;
            wdog_err_q    <= 1'b0;
            rec_cnt_q     <= '0;
        end else begin
            phase_q       <= phase_d;
            pc_q          <= pc_d;
            type_q        <= type_d;
            ptr_q         <= ptr_d;
            tail_q        <= tail_d;
            src_q         <= src_d;
            from_commit_q <= from_commit_d;
            wdog_cnt_q    <= wdog_cnt_d;
            wdog_err_q    <= wdog_err_d;
            rec_cnt_q     <= rec_cnt_d;
        end
    end

    assign phase                = phase_q;
    assign to_recovery_phase    = (phase_q == PH_RECOVER_0);
    assign to_commit_phase      = (phase_q == PH_RECOVER_1) && !busy;
    assign recovery_from_commit = from_commit_q;
    assign winner_src           = src_q;
    assign recovered_pc         = (phase_q == PH_RECOVER_0) ? refetch_pc(type_q, pc_q, csr_target) : '0;
    assign flush_head_ptr       = ((type_q == RT_THIS_PC) || (type_q == RT_THIS_PC_TO_CSR)) ? ptr_q : ptr_inc;
    assign flush_tail_ptr       = tail_q;
    assign sq_tail_inc          = (type_q == RT_STORE_NEXT_PC);
    assign csr_trigger          = (phase_q == PH_RECOVER_0) && is_csr_type(type_q) && (src_q == '0);
    assign unable_to_start      = (phase_q != PH_COMMIT) | busy | replay_flushed | wakeup_flushed;
    assign watchdog_err         = wdog_err_q;
    assign recovery_count       = rec_cnt_q;

endmodule

// File: tb/tb_recovery_arbiter.sv
// Self-checking bench for recovery_arbiter: directed scenarios plus randomized
// recoveries compared against a transaction-level model of the arbitration rules.
module tb_recovery_arbiter;

    localparam int NUM_SRC     = 3;
    localparam int ADDR_WIDTH  = 32;
    localparam int AL_DEPTH    = 64;
    localparam int INSN_BYTES  = 4;
    localparam int WDOG_CYCLES = 8;
    localparam int AL_IDX_W    = 6;
    localparam int SRC_W       = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_SRC-1:0]            req_valid;
    logic [NUM_SRC*AL_IDX_W-1:0]   req_al_ptr;
    logic [NUM_SRC*3-1:0]          req_refetch_type;
    logic [NUM_SRC*ADDR_WIDTH-1:0] req_pc;
    logic [AL_IDX_W-1:0]           al_head_ptr;
    logic [AL_IDX_W-1:0]           al_flush_tail_ptr;
    logic [ADDR_WIDTH-1:0]         csr_target;
    logic                          rmt_busy, iq_busy, replay_flushed, wakeup_flushed;
    logic [1:0]                    phase;
    logic                          to_recovery_phase, to_commit_phase, recovery_from_commit;
    logic [SRC_W-1:0]              winner_src;
    logic [ADDR_WIDTH-1:0]         recovered_pc;
    logic [AL_IDX_W-1:0]           flush_head_ptr, flush_tail_ptr;
    logic                          sq_tail_inc, csr_trigger, unable_to_start, watchdog_err;
    logic [31:0]                   recovery_count;

    recovery_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .AL_DEPTH    (AL_DEPTH),
        .INSN_BYTES  (INSN_BYTES),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_al_ptr           (req_al_ptr),
        .req_refetch_type     (req_refetch_type),
        .req_pc               (req_pc),
        .al_head_ptr          (al_head_ptr),
        .al_flush_tail_ptr    (al_flush_tail_ptr),
        .csr_target           (csr_target),
        .rmt_busy             (rmt_busy),
        .iq_busy              (iq_busy),
        .replay_flushed       (replay_flushed),
        .wakeup_flushed       (wakeup_flushed),
        .phase                (phase),
        .to_recovery_phase    (to_recovery_phase),
        .to_commit_phase      (to_commit_phase),
        .recovery_from_commit (recovery_from_commit),
        .winner_src           (winner_src),
        .recovered_pc         (recovered_pc),
        .flush_head_ptr       (flush_head_ptr),
        .flush_tail_ptr       (flush_tail_ptr),
        .sq_tail_inc          (sq_tail_inc),
        .csr_trigger          (csr_trigger),
        .unable_to_start      (unable_to_start),
        .watchdog_err         (watchdog_err),
        .recovery_count       (recovery_count)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_count = 0;

    // Request set for the next recovery: per-source valid, AL pointer, type, PC.
    int          v   [NUM_SRC];
    int          ptr [NUM_SRC];
    int          typ [NUM_SRC];
    logic [31:0] pcv [NUM_SRC];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_age(input int p, input int h);
        return ((p - h) % AL_DEPTH + AL_DEPTH) % AL_DEPTH;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NUM_SRC; i++) begin
            req_valid[i]                          = (v[i] != 0);
            req_al_ptr[i*AL_IDX_W +: AL_IDX_W]    = AL_IDX_W'(ptr[i]);
            req_refetch_type[i*3 +: 3]            = 3'(typ[i]);
            req_pc[i*ADDR_WIDTH +: ADDR_WIDTH]    = pcv[i];
        end
    endtask

    task automatic junk_reqs();
        req_valid         = NUM_SRC'($urandom);
        req_al_ptr        = (NUM_SRC*AL_IDX_W)'($urandom);
        req_refetch_type  = (NUM_SRC*3)'($urandom);
        req_pc            = {$urandom, $urandom, $urandom};
        al_head_ptr       = AL_IDX_W'($urandom);
        al_flush_tail_ptr = AL_IDX_W'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_phase"}, phase, 0);
        check_eq({tag, "_to_rec"}, to_recovery_phase, 0);
        check_eq({tag, "_to_commit"}, to_commit_phase, 0);
        check_eq({tag, "_from_commit"}, recovery_from_commit, 0);
        check_eq({tag, "_winner"}, winner_src, 0);
        check_eq({tag, "_rpc"}, recovered_pc, 0);
        check_eq({tag, "_fhead"}, flush_head_ptr, 0);
        check_eq({tag, "_ftail"}, flush_tail_ptr, 0);
        check_eq({tag, "_sq"}, sq_tail_inc, 0);
        check_eq({tag, "_csr"}, csr_trigger, 0);
        check_eq({tag, "_uts"}, unable_to_start, 0);
        check_eq({tag, "_wdog"}, watchdog_err, 0);
        check_eq({tag, "_count"}, recovery_count, 0);
    endtask

    // One full recovery: request cycle, RECOVER_0, busy_n busy RECOVER_1 cycles, release.
    task automatic run_recovery(input int head, input int tail, input logic [31:0] csr,
                                input int busy_n, input bit use_iq);
        int          w;
        int          t;
        logic [31:0] epc;
        int          efh;
        bit          rp, wk;
        w = -1;
        if (v[0] != 0) w = 0;
        else begin
            for (int i = 1; i < NUM_SRC; i++)
                if (v[i] != 0 && (w < 0 || model_age(ptr[i], head) < model_age(ptr[w], head))) w = i;
        end
        t = typ[w];
        if (w != 0 && t >= 4) t = 0;
        case (t)
            0, 2:    epc = pcv[w];
            1, 3:    epc = pcv[w] + 32'(INSN_BYTES);
            default: epc = csr;
        endcase
        efh = (t == 0 || t == 4) ? ptr[w] : (ptr[w] + 1) % AL_DEPTH;

        @(negedge clk);
        drive_reqs();
        al_head_ptr = AL_IDX_W'(head); al_flush_tail_ptr = AL_IDX_W'(tail); csr_target = csr;
        rmt_busy = 1'b0; iq_busy = 1'b0; replay_flushed = 1'b0; wakeup_flushed = 1'b0;
        #1;
        check_eq("req_phase", phase, 0);
        check_eq("req_uts", unable_to_start, 0);

        @(negedge clk);
        junk_reqs();
        rmt_busy = (busy_n > 0) && !use_iq;
        iq_busy  = (busy_n > 0) && use_iq;
        #1;
        check_eq("r0_phase", phase, 1);
        check_eq("r0_to_rec", to_recovery_phase, 1);
        check_eq("r0_to_commit", to_commit_phase, 0);
        check_eq("r0_winner", winner_src, 64'(w));
        check_eq("r0_from_commit", recovery_from_commit, (w == 0));
        check_eq("r0_rpc", recovered_pc, epc);
        check_eq("r0_fhead", flush_head_ptr, 64'(efh));
        check_eq("r0_ftail", flush_tail_ptr, 64'(tail));
        check_eq("r0_sq", sq_tail_inc, (t == 3));
        check_eq("r0_csr", csr_trigger, (t >= 4));
        check_eq("r0_uts", unable_to_start, 1);

        for (int k = 0; k < busy_n; k++) begin
            @(negedge clk);
            junk_reqs();
            #1;
            check_eq("r1_phase", phase, 2);
            check_eq("r1_to_commit", to_commit_phase, 0);
            check_eq("r1_rpc", recovered_pc, 0);
            check_eq("r1_csr", csr_trigger, 0);
            check_eq("r1_uts", unable_to_start, 1);
            check_eq("r1_wdog", watchdog_err, 0);
        end

        @(negedge clk);
        junk_reqs();
        rmt_busy = 1'b0; iq_busy = 1'b0;
        #1;
        check_eq("r1_end_phase", phase, 2);
        check_eq("r1_end_to_commit", to_commit_phase, 1);
        exp_count++;

        @(negedge clk);
        req_valid = '0;
        rp = 1'($urandom); wk = 1'($urandom);
        replay_flushed = rp; wakeup_flushed = wk;
        #1;
        check_eq("done_phase", phase, 0);
        check_eq("done_to_commit", to_commit_phase, 0);
        check_eq("done_count", recovery_count, 64'(exp_count));
        check_eq("done_uts", unable_to_start, (rp | wk));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_al_ptr = '0; req_refetch_type = '0; req_pc = '0;
        al_head_ptr = '0; al_flush_tail_ptr = '0; csr_target = '0;
        rmt_busy = 1'b0; iq_busy = 1'b0; replay_flushed = 1'b0; wakeup_flushed = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // rmt_busy for 5 RECOVER_1 cycles, first recovery after reset
        v = '{1, 0, 0}; ptr = '{7, 0, 0}; typ = '{0, 0, 0}; pcv = '{32'h1000, 0, 0};
        run_recovery(0, 20, 32'h0, 5, 0);

        // oldest across the wrap: head 60, ptr 2 (age 6) vs ptr 62 (age 2)
        v = '{0, 1, 1}; ptr = '{0, 2, 62}; typ = '{0, 1, 1}; pcv = '{0, 32'h200, 32'h300};
        run_recovery(60, 10, 32'h0, 0, 0);

        // commit-stage CSR trap beats an older lane
        v = '{1, 1, 0}; ptr = '{10, 3, 0}; typ = '{4, 0, 0}; pcv = '{32'h400, 32'h500, 0};
        run_recovery(0, 30, 32'h8000_0100, 1, 1);

        // NEXT_PC wraps the PC to zero
        v = '{0, 1, 0}; ptr = '{0, 5, 0}; typ = '{0, 1, 0}; pcv = '{0, 32'hFFFF_FFFC, 0};
        run_recovery(0, 9, 32'h0, 0, 0);

        // equal ages go to the lower index; CSR type from a lane becomes THIS_PC
        v = '{0, 1, 1}; ptr = '{0, 5, 5}; typ = '{0, 5, 3}; pcv = '{0, 32'h600, 32'h700};
        run_recovery(1, 2, 32'hDEAD_0000, 2, 1);

        // STORE_NEXT_PC at the last AL entry wraps the flush head
        v = '{0, 0, 1}; ptr = '{0, 0, 63}; typ = '{0, 0, 3}; pcv = '{0, 0, 32'h800};
        run_recovery(40, 50, 32'h0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                v[i]   = (i == 0) ? (($urandom_range(0, 3) == 0) ? 1 : 0) : int'($urandom_range(0, 1));
                ptr[i] = $urandom_range(0, AL_DEPTH - 1);
                typ[i] = $urandom_range(0, 5);
                pcv[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            end
            if (v[0] == 0 && v[1] == 0 && v[2] == 0) v[$urandom_range(1, 2)] = 1;
            run_recovery($urandom_range(0, AL_DEPTH - 1), $urandom_range(0, AL_DEPTH - 1),
                         $urandom, $urandom_range(0, 5), 1'($urandom));
        end

        // watchdog: iq_busy stuck, then reset out of RECOVER_1
        v = '{1, 0, 0}; ptr = '{12, 0, 0}; typ = '{0, 0, 0}; pcv = '{32'h900, 0, 0};
        @(negedge clk);
        drive_reqs();
        replay_flushed = 1'b0; wakeup_flushed = 1'b0;
        #1;
        check_eq("wd_req_phase", phase, 0);
        @(negedge clk);
        req_valid = '0; iq_busy = 1'b1;
        #1;
        check_eq("wd_r0_phase", phase, 1);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 3) junk_reqs();
            #1;
            check_eq("wd_phase", phase, 2);
            check_eq("wd_to_commit", to_commit_phase, 0);
            check_eq("wd_err", watchdog_err, (n >= WDOG_CYCLES));
        end
        @(negedge clk);
        rst = 1'b1; iq_busy = 1'b0; req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_count = 0;
        check_idle("wd_reset");

        // a request after reset starts a fresh recovery count
        v = '{0, 1, 0}; ptr = '{0, 33, 0}; typ = '{0, 2, 0}; pcv = '{0, 32'hA00, 0};
        run_recovery(30, 40, 32'h0, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
